trig_lookup_arbiter: RTL and testbench

Shares one sin/cos ROM pair among up to N requesters (player kart, opponent kart, future projectiles/camera) instead of instantiating a ROM pair per kart. Accepts angle lookups through a valid/ready handshake, arbitrates round-robin, sequences the fixed-latency ROM read, and returns the cos/sin pair tagged to the originating requester. Sits between the game-state update logic and the `cos.mem`/`sin.mem` ROMs.

---
 rtl/trig_lookup_arbiter_pkg.sv | 11 +
 rtl/trig_lookup_arbiter_if.sv | 25 ++
 rtl/trig_lookup_arbiter_rr_pick.sv | 33 +++
 rtl/trig_lookup_arbiter.sv | 82 ++++++++
 tb/tb_trig_lookup_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/trig_lookup_arbiter_pkg.sv
// Shared game-wide constants and types for angle and trig values.
// The arbiter normalises angles against ANGLE_FULL; TRIG_SCALE is the ROM fixed-point 1.0.
package trig_lookup_arbiter_pkg;

    localparam int ANGLE_FULL = 360;
    localparam int TRIG_SCALE = 512;

    typedef logic [8:0]         angle_t;
    typedef logic signed [10:0] trig_t;

endpackage

// File: rtl/trig_lookup_arbiter_if.sv
// Requester-side lookup bus: per-requester valid/ready/angle plus the tagged cos/sin response.
interface trig_lookup_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int ANGLE_W = 9,
    parameter int TRIG_W  = 11
);

    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0][ANGLE_W-1:0] req_angle;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ-1:0]              rsp_valid;
    logic signed [TRIG_W-1:0]      rsp_cos;
    logic signed [TRIG_W-1:0]      rsp_sin;

    modport master (
        output req_valid, req_angle,
        input  req_ready, rsp_valid, rsp_cos, rsp_sin
    );

    modport slave (
        input  req_valid, req_angle,
        output req_ready, rsp_valid, rsp_cos, rsp_sin
    );

endinterface

// File: rtl/trig_lookup_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/trig_lookup_arbiter.sv
// Shares one sin/cos ROM pair among N_REQ requesters: round-robin grant, angle wrap,
// fixed-latency tag pipeline so each ROM result returns to the requester that asked.
module trig_lookup_arbiter
    import trig_lookup_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ANGLE_W = 9,
    parameter int TRIG_W  = 11,
    parameter int ROM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    trig_lookup_arbiter_if.slave     lk,
    output logic [ANGLE_W-1:0]       rom_addr,
    input  logic signed [TRIG_W-1:0] rom_cos,
    input  logic signed [TRIG_W-1:0] rom_sin
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]              ptr;
    logic [N_REQ-1:0]              pick_grant;
    logic [IDX_W-1:0]              pick_idx;
    logic                          pick_found;
    logic                          xfer;
    logic [ANGLE_W-1:0]            sel_angle;
    logic [ANGLE_W-1:0]            norm_angle;
    logic [ANGLE_W-1:0]            addr_q;
    logic [ROM_LAT-1:0]            tag_valid;
    logic [ROM_LAT-1:0][N_REQ-1:0] tag_id;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (lk.req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Grants are suppressed while reset is held so nothing can slip into the pipeline.
    assign xfer         = rst_n & pick_found;
    assign lk.req_ready = rst_n ? pick_grant : '0;

    assign sel_angle  = lk.req_angle[pick_idx];
    assign norm_angle = (sel_angle >= ANGLE_W'(ANGLE_FULL)) ? (sel_angle - ANGLE_W'(ANGLE_FULL))
                                                            : sel_angle;

    // The ROM samples its address at the end of the grant cycle, so the new angle goes out directly.
    assign rom_addr = xfer ? norm_angle : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            addr_q       <= '0;
            tag_valid    <= '0;
            tag_id       <= '0;
            lk.rsp_valid <= '0;
            lk.rsp_cos   <= '0;
            lk.rsp_sin   <= '0;
        end else begin
            if (xfer) begin
                ptr    <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : (pick_idx + 1'b1);
                addr_q <= norm_angle;
            end
            tag_valid[0] <= xfer;
            tag_id[0]    <= xfer ? pick_grant : '0;
            for (int s = 1; s < ROM_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
            lk.rsp_valid <= tag_valid[ROM_LAT-1] ? tag_id[ROM_LAT-1] : '0;
            if (tag_valid[ROM_LAT-1]) begin
                lk.rsp_cos <= rom_cos;
                lk.rsp_sin <= rom_sin;
            end
        end
    end

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// Directed bench for trig_lookup_arbiter with a 2-cycle behavioural ROM pair.
// Each step drives inputs just after the rising edge and checks outputs on the falling edge.
module tb_trig_lookup_arbiter;
    import trig_lookup_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    angle_t      rom_addr;
    trig_t       rom_cos;
    trig_t       rom_sin;
    trig_t       rom_s1_cos;
    trig_t       rom_s1_sin;
    int          checks;
    int          failures;

    trig_lookup_arbiter_if #(.N_REQ(4), .ANGLE_W(9), .TRIG_W(11)) lk ();

    trig_lookup_arbiter #(
        .N_REQ   (4),
        .ANGLE_W (9),
        .TRIG_W  (11),
        .ROM_LAT (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lk       (lk),
        .rom_addr (rom_addr),
        .rom_cos  (rom_cos),
        .rom_sin  (rom_sin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact values for the angles the test plan names; any other angle returns (a, -a).
    function automatic trig_t cos_of(input angle_t a);
        int v;
        case (a)
            9'd0:    v = TRIG_SCALE;
            9'd90:   v = 0;
            9'd180:  v = -TRIG_SCALE;
            9'd270:  v = 0;
            9'd359:  v = TRIG_SCALE;
            default: v = int'(a);
        endcase
        return trig_t'(v);
    endfunction

    function automatic trig_t sin_of(input angle_t a);
        int v;
        case (a)
            9'd0:    v = 0;
            9'd90:   v = TRIG_SCALE;
            9'd180:  v = 0;
            9'd270:  v = -TRIG_SCALE;
            9'd359:  v = -9;
            default: v = -int'(a);
        endcase
        return trig_t'(v);
    endfunction

    initial begin
        rom_s1_cos = '0;
        rom_s1_sin = '0;
        rom_cos    = '0;
        rom_sin    = '0;
    end

    always @(posedge clk) begin
        rom_s1_cos <= cos_of(rom_addr);
        rom_s1_sin <= sin_of(rom_addr);
        rom_cos    <= rom_s1_cos;
        rom_sin    <= rom_s1_sin;
    end

    typedef struct {
        logic [3:0]      valid;
        logic [3:0][8:0] ang;
        logic [3:0]      exp_ready;
        angle_t          exp_addr;
        logic [3:0]      exp_rsp;
        int              exp_cos;
        int              exp_sin;
    } vec_t;

    vec_t tbl[9];

    task automatic check_field(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] v, input logic [3:0][8:0] a);
        lk.req_valid = v;
        lk.req_angle = a;
        #4;
    endtask

    task automatic check_output(input string name, input logic [3:0] er, input angle_t ea,
                                input logic [3:0] ers, input int ec, input int es);
        check_field($sformatf("%s.ready", name), int'(lk.req_ready), int'(er));
        check_field($sformatf("%s.addr", name), int'(rom_addr), int'(ea));
        check_field($sformatf("%s.rsp_valid", name), int'(lk.rsp_valid), int'(ers));
        check_field($sformatf("%s.cos", name), int'(lk.rsp_cos), ec);
        check_field($sformatf("%s.sin", name), int'(lk.rsp_sin), es);
    endtask

    task automatic step(input string name, input logic [3:0] v, input logic [3:0][8:0] a,
                        input logic [3:0] er, input angle_t ea, input logic [3:0] ers,
                        input int ec, input int es);
        apply_stimulus(v, a);
        check_output(name, er, ea, ers, ec, es);
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0][8:0] QUAD = {9'd270, 9'd180, 9'd90, 9'd0};
    localparam logic [3:0][8:0] ZERO = '0;

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        lk.req_valid = '0;
        lk.req_angle = '0;

        tbl[0] = '{4'b1111, QUAD, 4'b0001, 9'd0,   4'b0000, 0,    0};
        tbl[1] = '{4'b1111, QUAD, 4'b0010, 9'd90,  4'b0000, 0,    0};
        tbl[2] = '{4'b1111, QUAD, 4'b0100, 9'd180, 4'b0000, 0,    0};
        tbl[3] = '{4'b1111, QUAD, 4'b1000, 9'd270, 4'b0001, 512,  0};
        tbl[4] = '{4'b1111, QUAD, 4'b0001, 9'd0,   4'b0010, 0,    512};
        tbl[5] = '{4'b0000, ZERO, 4'b0000, 9'd0,   4'b0100, -512, 0};
        tbl[6] = '{4'b0000, ZERO, 4'b0000, 9'd0,   4'b1000, 0,    -512};
        tbl[7] = '{4'b0000, ZERO, 4'b0000, 9'd0,   4'b0001, 512,  0};
        tbl[8] = '{4'b0000, ZERO, 4'b0000, 9'd0,   4'b0000, 512,  0};

        @(posedge clk);
        #1;
        step("rst0", 4'b1111, QUAD, 4'b0000, 9'd0, 4'b0000, 0, 0);
        step("rst1", 4'b1111, QUAD, 4'b0000, 9'd0, 4'b0000, 0, 0);
        rst_n = 1'b1;

        // All four requesters active: round-robin from ptr 0, responses three cycles behind.
        for (int i = 0; i < 9; i++) begin
            step($sformatf("rr%0d", i), tbl[i].valid, tbl[i].ang, tbl[i].exp_ready,
                 tbl[i].exp_addr, tbl[i].exp_rsp, tbl[i].exp_cos, tbl[i].exp_sin);
        end

        // Angle wrap (511 -> 151, 450 -> 90, 359 unchanged) and single requester regardless of ptr.
        step("wrap0", 4'b0001, {9'd0, 9'd0, 9'd0, 9'd511},   4'b0001, 9'd151, 4'b0000, 512, 0);
        step("wrap1", 4'b0010, {9'd0, 9'd0, 9'd450, 9'd0},   4'b0010, 9'd90,  4'b0000, 512, 0);
        step("wrap2", 4'b0010, {9'd0, 9'd0, 9'd359, 9'd0},   4'b0010, 9'd359, 4'b0000, 512, 0);
        step("wrap3", 4'b0000, ZERO, 4'b0000, 9'd359, 4'b0001, 151, -151);
        step("wrap4", 4'b0000, ZERO, 4'b0000, 9'd359, 4'b0010, 0,   512);
        step("wrap5", 4'b0000, ZERO, 4'b0000, 9'd359, 4'b0010, 512, -9);
        step("wrap6", 4'b0000, ZERO, 4'b0000, 9'd359, 4'b0000, 512, -9);

        // ptr is 2: requesters 1 and 3 -> 3 then 1; the idle cycle must leave ptr and rom_addr alone.
        step("pair0", 4'b1010, {9'd20, 9'd0, 9'd10, 9'd0}, 4'b1000, 9'd20, 4'b0000, 512, -9);
        step("pair1", 4'b1010, {9'd20, 9'd0, 9'd10, 9'd0}, 4'b0010, 9'd10, 4'b0000, 512, -9);
        step("pair2", 4'b0000, ZERO,                       4'b0000, 9'd10, 4'b0000, 512, -9);
        step("pair3", 4'b1010, {9'd20, 9'd0, 9'd10, 9'd0}, 4'b1000, 9'd20, 4'b1000, 20,  -20);
        step("pair4", 4'b0000, ZERO, 4'b0000, 9'd20, 4'b0010, 10, -10);
        step("pair5", 4'b0000, ZERO, 4'b0000, 9'd20, 4'b0000, 10, -10);
        step("pair6", 4'b0000, ZERO, 4'b0000, 9'd20, 4'b1000, 20, -20);
        step("pair7", 4'b0000, ZERO, 4'b0000, 9'd20, 4'b0000, 20, -20);

        // Requester 2 withdraws before being granted; it must never see a response.
        step("wd0", 4'b0110, {9'd0, 9'd40, 9'd30, 9'd0},  4'b0010, 9'd30, 4'b0000, 20, -20);
        step("wd1", 4'b1001, {9'd60, 9'd0, 9'd0, 9'd50},  4'b1000, 9'd60, 4'b0000, 20, -20);
        step("wd2", 4'b0001, {9'd0, 9'd0, 9'd0, 9'd50},   4'b0001, 9'd50, 4'b0000, 20, -20);
        step("wd3", 4'b0000, ZERO, 4'b0000, 9'd50, 4'b0010, 30, -30);
        step("wd4", 4'b0000, ZERO, 4'b0000, 9'd50, 4'b1000, 60, -60);
        step("wd5", 4'b0000, ZERO, 4'b0000, 9'd50, 4'b0001, 50, -50);
        step("wd6", 4'b0000, ZERO, 4'b0000, 9'd50, 4'b0000, 50, -50);

        // Two lookups in flight when reset hits; none of them may surface afterwards.
        step("mid0", 4'b0011, {9'd0, 9'd0, 9'd80, 9'd70}, 4'b0010, 9'd80, 4'b0000, 50, -50);
        step("mid1", 4'b0001, {9'd0, 9'd0, 9'd0, 9'd70},  4'b0001, 9'd70, 4'b0000, 50, -50);
        rst_n = 1'b0;
        step("midrst0", 4'b1111, QUAD, 4'b0000, 9'd0, 4'b0000, 0, 0);
        step("midrst1", 4'b1111, QUAD, 4'b0000, 9'd0, 4'b0000, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("post%0d", i), 4'b0000, ZERO, 4'b0000, 9'd0, 4'b0000, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
